cobra_bus_mapper: RTL
=====================

// Module: cobra_bus_mapper
// PURPOSE
//  Parametrised CPU bus mapper for the Cobra1 core: replaces the fixed decode and relocation glue.
//  Maps the Z80 address with a reset-time relocation overlay and decodes ROM/VRAM/RAM selects.
//  Arbitrates the single-port VRAM between CPU and video with stall/wait-state insertion and bounded video preemption.
//  Sits between tv80s (wait_n input) and the memories / vga_controller, all in one clock domain.
// PARAMETERS
//  ADDR_W       16        CPU address width
//  RELOC_MASK   16'hC000  OR-mask applied to address while relocation active
//  RELOC_PORT   8'h1F     I/O port (addr[7:0]) whose write clears relocation
//  ROM_BASE     16'hC000  ROM window base; window size 2**ROM_LOG2
//  ROM_LOG2     11        log2 ROM window bytes
//  VRAM_BASE    16'hF800  VRAM window base; window runs to top of address space
//  VRAM_SETTLE  2         wait cycles after grant before CPU access completes (0..15)
//  MAX_STALL    8         max cycles CPU waits on vid_busy before preempting video (1..255)
// PORTS
//  clk           in   1       system clock (CPU clock)
//  rst           in   1       synchronous reset, active-high
//  cpu_a         in   ADDR_W  raw CPU address
//  cpu_mreq_n    in   1       memory request, active low
//  cpu_iorq_n    in   1       I/O request, active low
//  cpu_wr_n      in   1       write strobe, active low
//  vid_busy      in   1       video controller is fetching VRAM this cycle
//  mem_a         out  ADDR_W  mapped address (cpu_a | RELOC_MASK while reloc_active)
//  sel_rom       out  1       mapped address in ROM window (comb)
//  sel_vram      out  1       mapped address in VRAM window (comb)
//  sel_ram       out  1       neither ROM nor VRAM (comb)
//  ram_we        out  1       ~cpu_mreq_n & ~cpu_wr_n & sel_ram (comb)
//  vram_we       out  1       ~cpu_wr_n & vram_grant & state==ACCESS (comb)
//  vram_grant    out  1       CPU owns VRAM port; video must mux to CPU address (reg)
//  vid_preempt   out  1       one-cycle pulse: grant forced while vid_busy high (reg)
//  cpu_wait_n    out  1       Z80 WAIT, active low (reg)
//  reloc_active  out  1       relocation overlay enabled (reg)
// BEHAVIOUR
//  Reset: reloc_active=1, cpu_wait_n=1, vram_grant=0, vid_preempt=0, state=IDLE, counters=0.
//  Relocation: cleared (registered, effective next cycle) when ~cpu_iorq_n & ~cpu_wr_n & cpu_a[7:0]==RELOC_PORT.
//   Only reset sets it again. Decode always uses mem_a; ROM select is window match on mem_a, not cpu_a.
//  vram_req = ~cpu_mreq_n & sel_vram. FSM states IDLE, STALL, SETTLE, ACCESS:
//   IDLE:   vram_req & ~vid_busy -> SETTLE (grant=1, wait_n=0, settle_cnt=0); if VRAM_SETTLE==0 go ACCESS directly.
//           vram_req & vid_busy -> STALL (wait_n=0, stall_cnt=1).
//   STALL:  ~vid_busy -> SETTLE/ACCESS as above; stall_cnt==MAX_STALL -> grant anyway, vid_preempt=1 one cycle.
//           else stall_cnt++. ~vram_req (request withdrawn) -> IDLE, wait_n=1.
//   SETTLE: wait_n=0; settle_cnt++; at VRAM_SETTLE-1 -> ACCESS with wait_n=1 next cycle.
//   ACCESS: grant=1, wait_n=1; stay while cpu_mreq_n low; cpu_mreq_n high -> IDLE, grant=0 same edge.
//  Latency: uncontended VRAM access inserts exactly VRAM_SETTLE wait cycles; contended adds stall cycles (<=MAX_STALL).
//  Non-VRAM accesses never touch FSM; cpu_wait_n stays 1.
//  vid_busy while granted is ignored (CPU priority once granted).
//  Back-to-back VRAM cycles: mreq_n must go high for >=1 cycle; each cycle re-arbitrates from IDLE.
//  Reset mid-access: all outputs return to reset values next edge; no write enable asserted in reset cycle.
//  Counters saturate, never wrap; width = clog2(MAX_STALL+1) and 4 bits.
// TESTING
//  Reset, read 16'h0000 -> mem_a=16'hC000, sel_rom=1; OUT to 8'h1F -> next cycle reloc_active=0, 16'h0000 maps sel_ram=1.
//  OUT to 8'h1E, 8'h9F (addr[7:0]=9F) -> reloc_active stays 1; OUT 16'h011F -> clears.
//  Write F800, vid_busy=0, VRAM_SETTLE=2 -> wait_n low exactly 2 cycles, vram_we only in ACCESS, grant drops with mreq_n.
//  Write F800, vid_busy held high -> wait_n low MAX_STALL cycles, vid_preempt single pulse, then SETTLE/ACCESS.
//  vid_busy drops after 3 stall cycles -> no preempt pulse; total wait = 3+VRAM_SETTLE cycles.
//  rst asserted in SETTLE -> next cycle wait_n=1, grant=0, reloc_active=1, vram_we=0.

Source files
------------

// File: rtl/cobra_bus_mapper.sv
// cobra_bus_mapper
//   CPU bus mapper for the Cobra1 core. Applies the reset-time relocation
//   overlay to the Z80 address, decodes ROM / VRAM / RAM selects, and
//   arbitrates the single-port VRAM between the CPU and the video fetcher.
//   The CPU is held with WAIT while video owns VRAM (bounded by MAX_STALL,
//   after which video is preempted) and for VRAM_SETTLE cycles after grant.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   cpu_a         raw CPU address
//   cpu_mreq_n    memory request (active low)
//   cpu_iorq_n    I/O request (active low)
//   cpu_wr_n      write strobe (active low)
//   vid_busy      video is fetching VRAM this cycle
//   mem_a         mapped address
//   sel_rom/vram/ram  window decode of mem_a (combinational)
//   ram_we        RAM write enable (combinational)
//   vram_we       VRAM write enable, only in ACCESS (combinational)
//   vram_grant    CPU owns the VRAM port (registered)
//   vid_preempt   one-cycle pulse when grant was forced over vid_busy
//   cpu_wait_n    Z80 WAIT, active low (registered)
//   reloc_active  relocation overlay enabled (registered)

module cobra_bus_mapper #(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RELOC_MASK  = 16'hC000,
  parameter logic [7:0]        RELOC_PORT  = 8'h1F,
  parameter logic [ADDR_W-1:0] ROM_BASE    = 16'hC000,
  parameter int                ROM_LOG2    = 11,
  parameter logic [ADDR_W-1:0] VRAM_BASE   = 16'hF800,
  parameter int                VRAM_SETTLE = 2,
  parameter int                MAX_STALL   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic              cpu_mreq_n,
  input  logic              cpu_iorq_n,
  input  logic              cpu_wr_n,
  input  logic              vid_busy,
  output logic [ADDR_W-1:0] mem_a,
  output logic              sel_rom,
  output logic              sel_vram,
  output logic              sel_ram,
  output logic              ram_we,
  output logic              vram_we,
  output logic              vram_grant,
  output logic              vid_preempt,
  output logic              cpu_wait_n,
  output logic              reloc_active
);

  localparam int                SW          = $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0]     STALL_LIM   = SW'(MAX_STALL);
  localparam logic [SW-1:0]     STALL_ONE   = SW'(1);
  // Last settle count before ACCESS; unused when VRAM_SETTLE==0.
  localparam logic [3:0]        SETTLE_LAST = (VRAM_SETTLE > 0) ? 4'(VRAM_SETTLE - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] ROM_TAG     = ROM_BASE >> ROM_LOG2;

  typedef enum logic [1:0] {IDLE, STALL, SETTLE, ACCESS} state_t;

  state_t        state;
  logic [SW-1:0] stall_cnt;
  logic [3:0]    settle_cnt;
  logic          vram_req;
  logic          reloc_hit;

  // ---------------- address map / decode ----------------
  assign mem_a    = reloc_active ? (cpu_a | RELOC_MASK) : cpu_a;
  // Decode always follows the mapped address so the overlay steers
  // low-memory boot fetches into the ROM window.
  assign sel_rom  = ((mem_a >> ROM_LOG2) == ROM_TAG);
  assign sel_vram = (mem_a >= VRAM_BASE);
  assign sel_ram  = ~sel_rom & ~sel_vram;

  assign vram_req  = ~cpu_mreq_n & sel_vram;
  assign reloc_hit = ~cpu_iorq_n & ~cpu_wr_n & (cpu_a[7:0] == RELOC_PORT);

  // Write enables are suppressed during reset so a reset landing mid-cycle
  // can never commit a write.
  assign ram_we  = ~rst & ~cpu_mreq_n & ~cpu_wr_n & sel_ram;
  assign vram_we = ~rst & ~cpu_wr_n & vram_grant & (state == ACCESS);

  // ---------------- arbitration FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      stall_cnt    <= '0;
      settle_cnt   <= '0;
      vram_grant   <= 1'b0;
      vid_preempt  <= 1'b0;
      cpu_wait_n   <= 1'b1;
      reloc_active <= 1'b1;
    end else begin
      vid_preempt <= 1'b0;
      // Relocation is one-way: only reset can re-enable it.
      if (reloc_hit) reloc_active <= 1'b0;

      case (state)
        IDLE: begin
          if (vram_req) begin
            if (!vid_busy) begin
              vram_grant <= 1'b1;
              settle_cnt <= '0;
              stall_cnt  <= '0;
              if (VRAM_SETTLE == 0) begin
                state      <= ACCESS;
                cpu_wait_n <= 1'b1;
              end else begin
                state      <= SETTLE;
                cpu_wait_n <= 1'b0;
              end
            end else begin
              state      <= STALL;
              cpu_wait_n <= 1'b0;
              stall_cnt  <= STALL_ONE;
            end
          end
        end

        STALL: begin
          if (!vram_req) begin
            // CPU withdrew the request; release WAIT and re-arbitrate later.
            state      <= IDLE;
            cpu_wait_n <= 1'b1;
            stall_cnt  <= '0;
          end else if (!vid_busy || (stall_cnt == STALL_LIM)) begin
            // Either video finished or the stall budget is spent; in the
            // latter case video is forcibly preempted.
            vid_preempt <= vid_busy;
            vram_grant  <= 1'b1;
            settle_cnt  <= '0;
            stall_cnt   <= '0;
            if (VRAM_SETTLE == 0) begin
              state      <= ACCESS;
              cpu_wait_n <= 1'b1;
            end else begin
              state      <= SETTLE;
              cpu_wait_n <= 1'b0;
            end
          end else if (stall_cnt != STALL_LIM) begin
            stall_cnt <= stall_cnt + STALL_ONE;
          end
        end

        SETTLE: begin
          // WAIT is released one cycle early so it is already high on the
          // first ACCESS cycle.
          if (settle_cnt == SETTLE_LAST) begin
            state      <= ACCESS;
            cpu_wait_n <= 1'b1;
          end else begin
            cpu_wait_n <= 1'b0;
          end
          if (settle_cnt != 4'hF) settle_cnt <= settle_cnt + 4'd1;
        end

        ACCESS: begin
          // vid_busy is ignored here: once granted the CPU keeps the port
          // until its memory cycle ends.
          cpu_wait_n <= 1'b1;
          if (cpu_mreq_n) begin
            state      <= IDLE;
            vram_grant <= 1'b0;
            settle_cnt <= '0;
          end
        end

        default: begin
          state      <= IDLE;
          vram_grant <= 1'b0;
          cpu_wait_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
